// File: rtl/barcode_rdr.sv
// barcode_rdr
// ----------------------------------------------------------------------------
// Serial barcode decoder. The optical sensor line BC idles high; each frame
// starts with a low start bar whose width (in clk cycles) becomes the bit
// period. Eight data bars follow, MSB first. Each bar is sampled one period
// after its falling edge: a bar still low at that point is a 0 (wide bar), a
// bar already back high is a 1 (narrow bar). Frames whose upper two bits are
// 00 are accepted. They are presented on ID with a sticky ID_vld flag, which
// stays set until the consumer acknowledges it with clr_ID_vld.
//
// Parameters
//   TIMER_W     width of the period/timeout counter; an all-ones count aborts
//               the frame in progress
// Ports
//   clk         system clock, all logic on the rising edge
//   rst_n       synchronous active-low reset
//   BC          raw barcode sensor line (asynchronous, idle high)
//   clr_ID_vld  consumer acknowledge, clears ID_vld at the next edge
//   ID          last valid decoded ID (held, never cleared by acknowledge)
//   ID_vld      high while ID holds an unacknowledged valid ID
// ----------------------------------------------------------------------------
module barcode_rdr #(
  parameter int TIMER_W = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_FALL = 2'd2,
    SAMPLE    = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] CNT_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] CNT_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic               bc_meta_r;
  logic               bc_s_r;
  logic               bc_d_r;
  logic [TIMER_W-1:0] cnt_r;
  logic [TIMER_W-1:0] period_r;
  logic [7:0]         shft_r;
  logic [2:0]         bit_cnt_r;

  logic               fall_s;
  logic               timeout_s;
  logic               sample_hit_s;
  logic [7:0]         shft_nxt_s;
  logic               id_ok_s;

  // Falling edge of the synchronized line: delayed copy high, current low.
  assign fall_s       = bc_d_r & ~bc_s_r;
  // The counter saturating at all-ones means the line went quiet mid-frame.
  assign timeout_s    = &cnt_r;
  assign sample_hit_s = (cnt_r == period_r);
  assign shft_nxt_s   = {shft_r[6:0], bc_s_r};
  // Completion of the 8th bar with a value whose upper two bits are 00.
  assign id_ok_s      = (state_r == SAMPLE) & ~timeout_s & sample_hit_s &
                        (bit_cnt_r == 3'd7) & (shft_nxt_s[7:6] == 2'b00);

  // Two-flop synchronizer for BC plus one delay flop for edge detection;
  // all reset high so a line idling high never produces a false fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bc_meta_r <= 1'b1;
      bc_s_r    <= 1'b1;
      bc_d_r    <= 1'b1;
    end else begin
      bc_meta_r <= BC;
      bc_s_r    <= bc_meta_r;
      bc_d_r    <= bc_s_r;
    end
  end

  // Frame decode FSM together with the registered ID / ID_vld outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      period_r  <= CNT_ZERO;
      shft_r    <= 8'h00;
      bit_cnt_r <= 3'd0;
      ID        <= 8'h00;
      ID_vld    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // The fall-detect cycle itself counts as the first low cycle.
          if (fall_s) begin
            cnt_r   <= CNT_ONE;
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (timeout_s) begin
            state_r <= IDLE;
          end else if (!bc_s_r) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            // Start bar width in synchronized cycles becomes the bit period.
            period_r  <= cnt_r;
            cnt_r     <= CNT_ZERO;
            bit_cnt_r <= 3'd0;
            state_r   <= WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (timeout_s) begin
            state_r <= IDLE;
          end else if (fall_s) begin
            cnt_r   <= CNT_ONE;
            state_r <= SAMPLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        SAMPLE: begin
          // Falls are ignored here; only the sample point matters.
          if (timeout_s) begin
            state_r <= IDLE;
          end else if (sample_hit_s) begin
            shft_r    <= shft_nxt_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            cnt_r     <= CNT_ZERO;
            if (bit_cnt_r == 3'd7) begin
              state_r <= IDLE;
            end else begin
              state_r <= WAIT_FALL;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // A valid completion has priority over a same-cycle acknowledge.
      if (id_ok_s) begin
        ID     <= shft_nxt_s;
        ID_vld <= 1'b1;
      end else if (clr_ID_vld) begin
        ID_vld <= 1'b0;
      end else begin
        ID_vld <= ID_vld;
      end
    end
  end

endmodule

// File: tb/tb_barcode_rdr.sv
// Self-checking bench for barcode_rdr (TIMER_W = 8 so timeouts are short).
// Stimulus pushes expected IDs into a queue; a monitor forked from the main
// process pops and compares whenever the DUT presents a new valid ID.
module tb_barcode_rdr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       BC;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  barcode_rdr #(.TIMER_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BC         (BC),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .ID_vld     (ID_vld)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Watches for a new valid ID (ID_vld rising, or ID replaced while valid).
  task automatic monitor();
    logic       pv;
    logic [7:0] pid;
    logic [7:0] e;
    pv  = 1'b0;
    pid = 8'h00;
    forever begin
      @(negedge clk);
      if (ID_vld === 1'b1 && (!pv || ID !== pid)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_id: got 0x%02h, expected no new ID", ID);
        end else begin
          e = exp_q.pop_front();
          if (ID !== e) begin
            n_err++;
            $display("FAIL scoreboard_id: got 0x%02h, expected 0x%02h", ID, e);
          end
        end
      end
      pv  = ID_vld;
      pid = ID;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      BC = 1'b1;
    end
  endtask

  task automatic clear_vld();
    @(negedge clk);
    clr_ID_vld = 1'b1;
    @(negedge clk);
    clr_ID_vld = 1'b0;
  endtask

  // Start bar low for per cycles, high for per cycles, then nbits bars spaced
  // 2*per apart: 0-bar low 1.5*per, 1-bar low 0.5*per. With coll set, the
  // acknowledge is driven so that it is sampled on the completion edge of
  // the 8th bar (fall-detect edge + per cycles).
  task automatic send_frame(input logic [7:0] val, input int per, input int nbits,
                            input bit with_start, input bit coll);
    int  low;
    logic bitv;
    if (with_start) begin
      repeat (per) begin
        @(negedge clk);
        BC = 1'b0;
      end
      repeat (per) begin
        @(negedge clk);
        BC = 1'b1;
      end
    end
    for (int b = 0; b < nbits; b++) begin
      bitv = val[7-b];
      low  = bitv ? per / 2 : (per * 3) / 2;
      for (int i = 0; i < 2 * per; i++) begin
        @(negedge clk);
        BC         = (i < low) ? 1'b0 : 1'b1;
        clr_ID_vld = (coll && b == 7 && i == per + 2) ? 1'b1 : 1'b0;
      end
    end
    clr_ID_vld = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    BC         = 1'b1;
    clr_ID_vld = 1'b0;
    fork
      monitor();
    join_none

    // Reset with BC toggling: a start bar begun during reset is lost.
    @(negedge clk);
    BC = 1'b0;
    @(negedge clk);
    BC = 1'b1;
    @(negedge clk);
    check("reset_id", ID, 8'h00);
    check("reset_vld", 8'(ID_vld), 8'h00);
    check("reset_state", 8'(dut.state_r), 8'h00);
    rst_n = 1'b1;
    // Remaining data bars of that frame, without a start bar: must not decode.
    send_frame(8'h25, 100, 8, 1'b0, 1'b0);
    idle(320);
    check("lost_frame_vld", 8'(ID_vld), 8'h00);
    check("lost_frame_id", ID, 8'h00);

    // Valid frame, then acknowledge.
    exp_q.push_back(8'h25);
    send_frame(8'h25, 100, 8, 1'b1, 1'b0);
    idle(5);
    check("valid_id", ID, 8'h25);
    check("valid_vld", 8'(ID_vld), 8'h01);
    clear_vld();
    check("clr_vld", 8'(ID_vld), 8'h00);
    check("clr_id_held", ID, 8'h25);

    // Invalid frame is discarded; a following valid frame decodes.
    send_frame(8'hC5, 100, 8, 1'b1, 1'b0);
    idle(5);
    check("invalid_vld", 8'(ID_vld), 8'h00);
    check("invalid_id", ID, 8'h25);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 100, 8, 1'b1, 1'b0);
    idle(5);
    check("after_invalid_id", ID, 8'h11);
    check("after_invalid_vld", 8'(ID_vld), 8'h01);

    // Acknowledge in the completion cycle: set wins.
    exp_q.push_back(8'h3F);
    send_frame(8'h3F, 100, 8, 1'b1, 1'b1);
    idle(5);
    check("collision_id", ID, 8'h3F);
    check("collision_vld", 8'(ID_vld), 8'h01);
    // Overwrite without acknowledge.
    exp_q.push_back(8'h01);
    send_frame(8'h01, 100, 8, 1'b1, 1'b0);
    idle(5);
    check("overwrite_id", ID, 8'h01);
    check("overwrite_vld", 8'(ID_vld), 8'h01);

    // Timeout: 3 bars then the line stays high.
    clear_vld();
    send_frame(8'h2A, 20, 3, 1'b1, 1'b0);
    idle(320);
    check("timeout_vld", 8'(ID_vld), 8'h00);
    check("timeout_id", ID, 8'h01);
    exp_q.push_back(8'h2A);
    send_frame(8'h2A, 20, 8, 1'b1, 1'b0);
    idle(5);
    check("post_timeout_id", ID, 8'h2A);
    check("post_timeout_vld", 8'(ID_vld), 8'h01);

    // Reset after 4 bars of a frame.
    clear_vld();
    send_frame(8'h15, 100, 4, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_id", ID, 8'h00);
    check("midreset_vld", 8'(ID_vld), 8'h00);
    idle(20);
    exp_q.push_back(8'h15);
    send_frame(8'h15, 100, 8, 1'b1, 1'b0);
    idle(5);
    check("post_reset_id", ID, 8'h15);
    check("post_reset_vld", 8'(ID_vld), 8'h01);

    idle(5);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending IDs, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
